// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the core's single memory/peripheral bus between
// instruction fetch (IF) and the load/store unit (LS). One transaction is in
// flight at a time. LS has fixed priority, but IF is forced through after
// STARVE_MAX consecutive LS wins. A silent slave is answered with an error
// completion after TIMEOUT busy cycles.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_be_i,
    output logic                ls_gnt_o,
    output logic                ls_rvalid_o,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                ls_err_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    output logic [DATA_W/8-1:0] bus_be_o,
    input  logic                bus_ack_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            owner_ls;
    logic [TO_W-1:0] to_cnt;
    logic [SV_W-1:0] starve_cnt;
    logic            grant_ls;
    logic            grant_if;
    logic            ack_done;
    logic            timeout_done;
    logic            if_forced;

    assign if_forced = if_req_i && (starve_cnt == SV_W'(STARVE_MAX));

    // Next-state logic: arbitration in IDLE, ack/timeout detection in BUSY.
    always_comb begin
        state_next   = state;
        grant_ls     = 1'b0;
        grant_if     = 1'b0;
        ack_done     = 1'b0;
        timeout_done = 1'b0;
        case (state)
            IDLE: begin
                if (ls_req_i && !if_forced) begin
                    grant_ls = 1'b1;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                end
                if (grant_ls || grant_if) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus_ack_i) begin
                    ack_done   = 1'b1;
                    state_next = RESP;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout_done = 1'b1;
                    state_next   = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bus request side: latch the winner's attributes and pulse its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_be_o    <= '0;
            owner_ls    <= 1'b0;
            if_gnt_o    <= 1'b0;
            ls_gnt_o    <= 1'b0;
        end else begin
            if_gnt_o <= grant_if;
            ls_gnt_o <= grant_ls;
            if (grant_ls) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= ls_we_i;
                bus_addr_o  <= ls_addr_i;
                bus_wdata_o <= ls_wdata_i;
                bus_be_o    <= ls_be_i;
                owner_ls    <= 1'b1;
            end else if (grant_if) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= 1'b0;
                bus_addr_o  <= if_addr_i;
                bus_wdata_o <= '0;
                bus_be_o    <= '1;
                owner_ls    <= 1'b0;
            end else if (ack_done || timeout_done) begin
                bus_req_o <= 1'b0;
            end
        end
    end

    // Busy-cycle counter, only runs while waiting for the slave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == BUSY && state_next == BUSY) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Count LS wins that left IF waiting; an IF win or an idle IF clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if || !if_req_i) begin
                starve_cnt <= '0;
            end else if (grant_ls && starve_cnt != SV_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Completion: pulse the owner's rvalid and update only its rdata/err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
            if_err_o    <= 1'b0;
            ls_err_o    <= 1'b0;
        end else begin
            if_rvalid_o <= 1'b0;
            ls_rvalid_o <= 1'b0;
            if (ack_done || timeout_done) begin
                if (owner_ls) begin
                    ls_rvalid_o <= 1'b1;
                    ls_err_o    <= timeout_done;
                    ls_rdata_o  <= (ack_done && !bus_we_o) ? bus_rdata_i : '0;
                end else begin
                    if_rvalid_o <= 1'b1;
                    if_err_o    <= timeout_done;
                    if_rdata_o  <= ack_done ? bus_rdata_i : '0;
                end
            end
        end
    end

endmodule
